axi_default_slave: RTL

- Terminates AXI4 transactions whose address the interconnect decoder flags as unmapped (decoder `error_o` = 1).
- Sits directly downstream of the address decoder, on the slave-side port the crossbar routes to when no slave matches.
- Accepts the full write burst and returns one DECERR write response.
- For reads, returns `arlen_i`+1 beats of zero data with DECERR, with `rlast_o` on the final beat.

---
 rtl/axi_pkg.sv | 27 ++
 rtl/axi_default_slave.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/axi_pkg.sv
// AXI helper types shared by the default slave and crossbar glue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

    // Burst length fields (AxLEN) are 8 bits wide in AXI4.
    localparam int unsigned AxiLenWidth = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_default_slave.sv
// Default slave: terminates unmapped AXI4 bursts with DECERR (write: drain W, one B; read: arlen+1 zero beats).
// Latency: AW/AR handshake -> W accept / first R beat next cycle; wlast handshake -> B next cycle.
// Backpressure: bvalid/rvalid held with stable payload until bready/rready; one outstanding txn per path.
// Ports: clk_i/rst_i (sync, active-high); AW/W/B write channel subset; AR/R read channel subset.
//        awlen_i is accepted but unused: wlast_i alone terminates the write burst.
module axi_default_slave
    import axi_pkg::*;
#(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // write address
    input  logic [IdWidth-1:0]     awid_i,
    input  logic [AxiLenWidth-1:0] awlen_i,
    input  logic                   awvalid_i,
    output logic                   awready_o,
    // write data
    input  logic                   wlast_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    // write response
    output logic [IdWidth-1:0]     bid_o,
    output logic [1:0]             bresp_o,
    output logic                   bvalid_o,
    input  logic                   bready_i,
    // read address
    input  logic [IdWidth-1:0]     arid_i,
    input  logic [AxiLenWidth-1:0] arlen_i,
    input  logic                   arvalid_i,
    output logic                   arready_o,
    // read data
    output logic [IdWidth-1:0]     rid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [1:0]             rresp_o,
    output logic                   rlast_o,
    output logic                   rvalid_o,
    input  logic                   rready_i
);

    wr_state_e              wr_state_q, wr_state_d;
    logic [IdWidth-1:0]     bid_q, bid_d;

    rd_state_e              rd_state_q, rd_state_d;
    logic [IdWidth-1:0]     rid_q, rid_d;
    logic [AxiLenWidth-1:0] cnt_q, cnt_d;

    // Burst length is not checked on writes; keep the port without a dangling-input warning.
    logic unused_awlen;
    assign unused_awlen = ^awlen_i;

    // ---------------- write path ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            bid_q      <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            bid_q      <= bid_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        bid_d      = bid_q;
        case (wr_state_q)
            W_IDLE: begin
                if (awvalid_i) begin
                    bid_d      = awid_i;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // Data beats are discarded; only wlast matters.
                if (wvalid_i && wlast_i) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign awready_o = (wr_state_q == W_IDLE);
    assign wready_o  = (wr_state_q == W_DATA);
    assign bvalid_o  = (wr_state_q == W_RESP);
    assign bid_o     = bid_q;
    assign bresp_o   = RESP_DECERR;

    // ---------------- read path ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= R_IDLE;
            rid_q      <= '0;
            cnt_q      <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        cnt_d      = cnt_q;
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid_i) begin
                    rid_d      = arid_i;
                    cnt_d      = arlen_i;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                // cnt_q counts beats remaining after the current one; it stops at zero
                // so a 256-beat burst never wraps.
                if (rready_i) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - {{(AxiLenWidth-1){1'b0}}, 1'b1};
                    end else begin
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign arready_o = (rd_state_q == R_IDLE);
    assign rvalid_o  = (rd_state_q == R_DATA);
    assign rlast_o   = (rd_state_q == R_DATA) && (cnt_q == '0);
    assign rid_o     = rid_q;
    assign rdata_o   = '0;
    assign rresp_o   = RESP_DECERR;

endmodule
